// File: rtl/wb_bbox_extract.sv
// wb_bbox_extract
//   Per-frame bounding box and area of white pixels from the erosion stage.
//   Rows with fewer than MIN_ROW_PIX white pixels do not count toward the
//   vertical extent. Results are published two cycles after pixel
//   (H_ACT-1, V_ACT-1), together with a one-cycle o_done pulse.
//
// Ports
//   pre_clk            pixel clock
//   rst                synchronous active-high reset
//   i_valid, i_wb      pixel strobe and white/black bit
//   i_x, i_y           10-bit pixel column / row
//   o_x0, o_x1         left / right box edge
//   o_y0, o_y1         top / bottom occupied row
//   o_area             white pixel count of the last frame
//   o_found            last frame had area >= MIN_AREA and an occupied row
//   o_done             one-cycle pulse when the outputs update
//
// Build option
//   BBOX_SMOOTH_EN     when defined, a found frame's box is averaged with the
//                      previously published box (first found frame loads raw)
//
// State | meaning
// IDLE  | waiting for a valid pixel at (0,0)
// ACCUM | accumulating the current frame
// LATCH | last pixel taken; final values are snapshotted this cycle
module wb_bbox_extract #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int MIN_ROW_PIX = 4,
  parameter int MIN_AREA    = 64,
  parameter int AREA_W      = 19
) (
  input  logic              pre_clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_wb,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  output logic [9:0]        o_x0,
  output logic [9:0]        o_x1,
  output logic [9:0]        o_y0,
  output logic [9:0]        o_y1,
  output logic [AREA_W-1:0] o_area,
  output logic              o_found,
  output logic              o_done
);

  localparam logic [9:0]        X_LAST   = 10'(H_ACT - 1);
  localparam logic [9:0]        Y_LAST   = 10'(V_ACT - 1);
  localparam logic [9:0]        ROW_MIN  = 10'(MIN_ROW_PIX);
  localparam logic [AREA_W-1:0] AREA_MIN = AREA_W'(MIN_AREA);

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;
  state_t state, state_nxt;

  logic [9:0]        xmin, xmax, ymin, ymax, rowcnt;
  logic              occ;
  logic [AREA_W-1:0] area;
  logic              row_pend, row_ok;
  logic [9:0]        row_y;

  logic [9:0]        res_x0, res_x1, res_y0, res_y1;
  logic [AREA_W-1:0] res_area;
  logic              res_found, pub_pend;

  logic              pix_ok, is_start, line_end, frame_last, accept;
  logic [9:0]        eff_ymin, eff_ymax;
  logic              eff_occ;
  logic [9:0]        n_xmin, n_xmax, n_ymin, n_ymax, n_rowcnt, row_incl;
  logic              n_occ, row_ok_nxt;
  logic [AREA_W-1:0] n_area;

`ifdef BBOX_SMOOTH_EN
  logic have_prev;

  function automatic logic [9:0] avg(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10:1];
  endfunction
`endif

  assign pix_ok     = i_valid && (i_x <= X_LAST) && (i_y <= Y_LAST);
  assign is_start   = pix_ok && (i_x == 10'd0) && (i_y == 10'd0);
  assign line_end   = pix_ok && (i_x == X_LAST);
  assign frame_last = line_end && (i_y == Y_LAST);
  // A (0,0) pixel is taken in any state; it also restarts a frame in ACCUM.
  assign accept     = is_start || ((state == ACCUM) && pix_ok);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_start) state_nxt = ACCUM;
      ACCUM:   if (frame_last) state_nxt = LATCH;
      LATCH:   state_nxt = is_start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // Vertical extent with the previous line's evaluation folded in.
    eff_ymin = ymin;
    eff_ymax = ymax;
    eff_occ  = occ;
    if (row_pend && row_ok) begin
      if (row_y < ymin) eff_ymin = row_y;
      if (row_y > ymax) eff_ymax = row_y;
      eff_occ = 1'b1;
    end

    n_xmin   = xmin;
    n_xmax   = xmax;
    n_ymin   = eff_ymin;
    n_ymax   = eff_ymax;
    n_occ    = eff_occ;
    n_area   = area;
    n_rowcnt = rowcnt;
    // Restart drops any pending row of the old frame along with the rest.
    if (is_start) begin
      n_xmin   = X_LAST;
      n_xmax   = '0;
      n_ymin   = Y_LAST;
      n_ymax   = '0;
      n_occ    = 1'b0;
      n_area   = '0;
      n_rowcnt = '0;
    end
    if (accept && i_wb) begin
      if (n_area != '1) n_area = n_area + 1'b1;
      if (i_x < n_xmin) n_xmin = i_x;
      if (i_x > n_xmax) n_xmax = i_x;
      if (n_rowcnt != 10'h3FF) n_rowcnt = n_rowcnt + 10'd1;
    end
    row_incl   = n_rowcnt;
    row_ok_nxt = (row_incl >= ROW_MIN);
    if (accept && line_end) n_rowcnt = '0;
  end

  always_ff @(posedge pre_clk) begin
    if (rst) begin
      state     <= IDLE;
      xmin      <= X_LAST;
      xmax      <= '0;
      ymin      <= Y_LAST;
      ymax      <= '0;
      occ       <= 1'b0;
      area      <= '0;
      rowcnt    <= '0;
      row_pend  <= 1'b0;
      row_ok    <= 1'b0;
      row_y     <= '0;
      res_x0    <= '0;
      res_x1    <= '0;
      res_y0    <= '0;
      res_y1    <= '0;
      res_area  <= '0;
      res_found <= 1'b0;
      pub_pend  <= 1'b0;
      o_x0      <= '0;
      o_x1      <= '0;
      o_y0      <= '0;
      o_y1      <= '0;
      o_area    <= '0;
      o_found   <= 1'b0;
      o_done    <= 1'b0;
`ifdef BBOX_SMOOTH_EN
      have_prev <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      xmin     <= n_xmin;
      xmax     <= n_xmax;
      ymin     <= n_ymin;
      ymax     <= n_ymax;
      occ      <= n_occ;
      area     <= n_area;
      rowcnt   <= n_rowcnt;
      row_pend <= accept && line_end;
      row_ok   <= row_ok_nxt;
      row_y    <= i_y;

      // Snapshot lets a new frame start in the same cycle without disturbing
      // the values about to be published.
      pub_pend <= (state == LATCH);
      if (state == LATCH) begin
        res_x0    <= xmin;
        res_x1    <= xmax;
        res_y0    <= eff_ymin;
        res_y1    <= eff_ymax;
        res_area  <= area;
        res_found <= (area >= AREA_MIN) && eff_occ;
      end

      o_done <= pub_pend;
      if (pub_pend) begin
        o_area  <= res_area;
        o_found <= res_found;
        if (res_found) begin
`ifdef BBOX_SMOOTH_EN
          if (have_prev) begin
            o_x0 <= avg(o_x0, res_x0);
            o_x1 <= avg(o_x1, res_x1);
            o_y0 <= avg(o_y0, res_y0);
            o_y1 <= avg(o_y1, res_y1);
          end else begin
            o_x0 <= res_x0;
            o_x1 <= res_x1;
            o_y0 <= res_y0;
            o_y1 <= res_y1;
          end
          have_prev <= 1'b1;
`else
          o_x0 <= res_x0;
          o_x1 <= res_x1;
          o_y0 <= res_y0;
          o_y1 <= res_y1;
`endif
        end
      end
    end
  end

endmodule
